data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 165 ++++++++++++++++
 tb/tb_data_memory.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Byte-addressable data memory of DEPTH little-endian 32-bit words. It has one
// load/store port and a combinational debug read port.
//
// Ports
//   clk            in   1   single clock, all state changes on the rising edge
//   reset          in   1   asynchronous, active-low reset (clears data_out only)
//   addr           in  32   byte address of the load/store port
//   data_in        in  32   store data, right-justified (byte [7:0], half [15:0])
//   data_out       out 32   registered load result, sign-extended for LB/LH
//   read_en        in   1   load request
//   write_en       in   1   store request
//   byte_enable    in   4   0001 byte, 0011 halfword, 1111 word, else lane mask
//   debug_addr     in  32   byte address of the debug port (bits [1:0] ignored)
//   debug_data_out out 32   raw word at debug_addr, combinational
//
// Parameters
//   DEPTH      number of 32-bit words (address wraps modulo 2**clog2(DEPTH))
//   INIT_FILE  name of a hex image; not read by this model
//
// Configuration
//   Every word powers up as zero.
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = "compiler/data.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] debug_addr,
    output logic [31:0] debug_data_out
);

    // Word-index width; a one-word memory still needs a 1-bit index.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [31:0]   mem_r [DEPTH];

    logic [AW-1:0] word_idx_s;
    logic [AW-1:0] debug_idx_s;
    logic [1:0]    lane_off_s;

    logic [3:0]    wr_mask_s;
    logic [31:0]   wr_data_s;

    logic [31:0]   rd_word_s;
    logic [7:0]    rd_byte_s;
    logic [15:0]   rd_half_s;
    logic [31:0]   load_s;

    // Only the low AW bits of the word address are decoded; higher bits alias.
    assign word_idx_s  = addr[AW+1:2];
    assign debug_idx_s = debug_addr[AW+1:2];
    assign lane_off_s  = addr[1:0];

    // Upper address bits and the debug lane offset are deliberately ignored.
    logic unused_s;
    assign unused_s = ^{addr[31:AW+2], debug_addr[31:AW+2], debug_addr[1:0]};

    localparam int init_file_unused = $bits(INIT_FILE);

    // Power-up contents of the array.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] = 32'h0000_0000;
        end
    end

    // -------------------------------------------------------------------------
    // Store path
    // -------------------------------------------------------------------------

    // Align mask and data to the addressed lane. The 4-bit / 32-bit results
    // truncate anything shifted past lane 3, so a misaligned access can never
    // spill into the following word.
    always_comb begin
        wr_mask_s = 4'b0000;
        wr_data_s = 32'h0000_0000;
        if (write_en) begin
            wr_mask_s = byte_enable << lane_off_s;
            wr_data_s = data_in << {lane_off_s, 3'b000};
        end else begin
            wr_mask_s = 4'b0000;
            wr_data_s = 32'h0000_0000;
        end
    end

    // Per-lane array write; reset suppresses stores but never clears the array.
    always_ff @(posedge clk) begin
        if (reset && write_en) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (wr_mask_s[lane]) begin
                    mem_r[word_idx_s][8*lane +: 8] <= wr_data_s[8*lane +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Load path
    // -------------------------------------------------------------------------

    // Old word contents; sampling these at the clock edge gives read-before-write.
    assign rd_word_s = mem_r[word_idx_s];

    // Byte lane selected by addr[1:0].
    always_comb begin
        rd_byte_s = 8'h00;
        case (lane_off_s)
            2'd0:    rd_byte_s = rd_word_s[7:0];
            2'd1:    rd_byte_s = rd_word_s[15:8];
            2'd2:    rd_byte_s = rd_word_s[23:16];
            2'd3:    rd_byte_s = rd_word_s[31:24];
            default: rd_byte_s = rd_word_s[7:0];
        endcase
    end

    // Halfword selected by addr[1]; addr[0] is ignored for halfwords.
    always_comb begin
        rd_half_s = 16'h0000;
        if (lane_off_s[1]) begin
            rd_half_s = rd_word_s[31:16];
        end else begin
            rd_half_s = rd_word_s[15:0];
        end
    end

    // Size decode and sign extension; any non-byte/half pattern returns the word.
    always_comb begin
        load_s = 32'h0000_0000;
        case (byte_enable)
            4'b0001: load_s = {{24{rd_byte_s[7]}}, rd_byte_s};
            4'b0011: load_s = {{16{rd_half_s[15]}}, rd_half_s};
            default: load_s = rd_word_s;
        endcase
    end

    // Load result register: asynchronously cleared, holds when read_en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= 32'h0000_0000;
        end else if (read_en) begin
            data_out <= load_s;
        end
    end

    // -------------------------------------------------------------------------
    // Debug port
    // -------------------------------------------------------------------------

    // Raw word, independent of the load/store port and of reset.
    assign debug_data_out = mem_r[debug_idx_s];

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//
// Directed bench for data_memory. Loads push their hand-computed expected
// result into a scoreboard queue; a monitor process pops and compares one
// entry per clock in which the DUT accepted a load. Debug-port and reset
// behaviour are compared directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_data_memory;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        read_en;
    logic        write_en;
    logic [3:0]  byte_enable;
    logic [31:0] debug_addr;
    logic [31:0] debug_data_out;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic load_seen = 1'b0;

    data_memory #(.DEPTH(1024)) dut (
        .clk            (clk),
        .reset          (reset),
        .addr           (addr),
        .data_in        (data_in),
        .data_out       (data_out),
        .read_en        (read_en),
        .write_en       (write_en),
        .byte_enable    (byte_enable),
        .debug_addr     (debug_addr),
        .debug_data_out (debug_data_out)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Remember whether the DUT accepted a load on this edge.
    always @(posedge clk) begin
        load_seen <= read_en && reset;
    end

    // Monitor: one response per accepted load, sampled on the falling edge.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (load_seen) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, data_out, e.exp);
                end
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr = a; data_in = d; byte_enable = be;
        write_en = 1'b1; read_en = 1'b0;
    endtask

    task automatic load(input string name, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] exp);
        sb_entry_t e;
        @(negedge clk);
        addr = a; byte_enable = be;
        read_en = 1'b1; write_en = 1'b0;
        e.name = name; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        read_en = 1'b0; write_en = 1'b0;
    endtask

    task automatic dbg(input string name, input logic [31:0] a, input logic [31:0] exp);
        idle();
        debug_addr = a;
        #1;
        check(name, debug_data_out, exp);
    endtask

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        sb_entry_t e;
        addr = 32'h0; data_in = 32'h0; read_en = 1'b0; write_en = 1'b0;
        byte_enable = 4'b0000; debug_addr = 32'h0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset_data_out", data_out, 32'h0000_0000);
        check("init_dbg_0", debug_data_out, 32'h0000_0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Basic stores and debug readback.
        store(32'h00, 32'h0000_00AB, 4'b0001);
        store(32'h04, 32'h0000_C0DE, 4'b0011);
        store(32'h08, 32'hDEAD_BEEF, 4'b1111);
        dbg("dbg_sb_00", 32'h00, 32'h0000_00AB);
        dbg("dbg_sh_04", 32'h04, 32'h0000_C0DE);
        dbg("dbg_sw_08", 32'h08, 32'hDEAD_BEEF);

        // Loads with sign extension.
        load("lb_00", 32'h00, 4'b0001, 32'hFFFF_FFAB);
        load("lb_08", 32'h08, 4'b0001, 32'hFFFF_FFEF);
        load("lb_09", 32'h09, 4'b0001, 32'hFFFF_FFBE);
        load("lb_0a", 32'h0A, 4'b0001, 32'hFFFF_FFAD);
        load("lb_0b", 32'h0B, 4'b0001, 32'hFFFF_FFDE);
        load("lh_04", 32'h04, 4'b0011, 32'hFFFF_C0DE);
        load("lh_0a", 32'h0A, 4'b0011, 32'hFFFF_DEAD);
        load("lh_0b", 32'h0B, 4'b0011, 32'hFFFF_DEAD);
        load("lw_08", 32'h08, 4'b1111, 32'hDEAD_BEEF);

        // Non-contiguous lane masks.
        store(32'h10, 32'h0000_1200, 4'b0010);
        store(32'h10, 32'h0034_0000, 4'b0100);
        load("lw_10_mask", 32'h10, 4'b1111, 32'h0034_1200);
        dbg("dbg_10_mask", 32'h10, 32'h0034_1200);

        // Misaligned stores, truncated at lane 3.
        store(32'h13, 32'h0000_0077, 4'b0001);
        store(32'h17, 32'h0000_AAAA, 4'b0011);
        dbg("dbg_10_sb13", 32'h10, 32'h7734_1200);
        dbg("dbg_14_sh17", 32'h14, 32'hAA00_0000);
        dbg("dbg_18_nospill", 32'h18, 32'h0000_0000);
        load("lb_11_pos", 32'h11, 4'b0001, 32'h0000_0012);
        load("lh_12_pos", 32'h12, 4'b0011, 32'h0000_7734);
        load("lw_10_be0110", 32'h10, 4'b0110, 32'h7734_1200);

        // Hold, then asynchronous mid-cycle reset pulse.
        load("lw_08_again", 32'h08, 4'b1111, 32'hDEAD_BEEF);
        idle();
        idle();
        idle();
        check("hold_data_out", data_out, 32'hDEAD_BEEF);
        #2 reset = 1'b0;
        #1;
        check("async_reset", data_out, 32'h0000_0000);
        #1 reset = 1'b1;
        dbg("dbg_08_after_rst", 32'h08, 32'hDEAD_BEEF);

        // Stores and loads suppressed while reset is low; debug still works.
        @(negedge clk);
        reset = 1'b0;
        addr = 32'h20; data_in = 32'hFFFF_FFFF; byte_enable = 4'b1111;
        write_en = 1'b1; read_en = 1'b1; debug_addr = 32'h08;
        #1;
        check("dbg_in_reset", debug_data_out, 32'hDEAD_BEEF);
        @(negedge clk);
        write_en = 1'b0; read_en = 1'b0; debug_addr = 32'h20;
        #1;
        check("store_suppressed", debug_data_out, 32'h0000_0000);
        check("load_suppressed", data_out, 32'h0000_0000);
        reset = 1'b1;

        // Read-before-write on the same word.
        @(negedge clk);
        addr = 32'h08; data_in = 32'h1234_5678; byte_enable = 4'b1111;
        read_en = 1'b1; write_en = 1'b1;
        e.name = "rbw_old_data"; e.exp = 32'hDEAD_BEEF;
        sb_q.push_back(e);
        dbg("rbw_write_done", 32'h08, 32'h1234_5678);

        // Address wrap.
        store(32'h0000_1000, 32'h1111_1111, 4'b1111);
        dbg("wrap_dbg_00", 32'h00, 32'h1111_1111);
        load("wrap_lw_1000", 32'h0000_1000, 4'b1111, 32'h1111_1111);

        idle();
        idle();
        idle();
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
